// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_UMUL = 2'b00,
    OP_SMUL = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative multiply/divide with Start/Busy/Done handshake.
// Optional macro MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are 0.
module mcycle_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               arm_q, arm_d;
  logic               is_div_q, zdiv_q, neg_lo_q, neg_hi_q, div_zero_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, load_acc, fin_src, prod_fix;
  logic [WIDTH-1:0]   mplier_q, mplier_d, result1_q, result2_q, quo_fix, rem_fix;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               is_signed, is_div, a_neg, b_neg, b_zero, accept, last;

  // Start-edge decode and operand magnitudes
  assign is_div    = (Op == OP_UDIV) || (Op == OP_SDIV);
  assign is_signed = (Op == OP_SMUL) || (Op == OP_SDIV);
  assign a_neg     = is_signed & SrcA[WIDTH-1];
  assign b_neg     = is_signed & SrcB[WIDTH-1];
  assign b_zero    = is_div & (SrcB == '0);
  assign accept    = Start & (((state_q == S_IDLE) & ~arm_q) | (state_q == S_FIN));

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.neg_i(a_neg), .a_i(SrcA), .y_o(a_abs));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.neg_i(b_neg), .a_i(SrcB), .y_o(b_abs));

  // Divide-by-zero parks {SrcA, all-ones} in the accumulator so FIN just copies it out
  assign load_acc = b_zero ? {SrcA, {WIDTH{1'b1}}} :
                    is_div ? {{WIDTH{1'b0}}, a_abs} : {2*WIDTH{1'b0}};

  // One iteration: restoring divide step or shift-add multiply step
  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (is_div_q) begin
      acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  assign last = (cnt_q == '0) | (~is_div_q & (mplier_q[WIDTH-1:1] == '0));
`else
  assign last = (cnt_q == '0);
`endif

  // Sign correction on the value about to be committed
  assign fin_src = (state_q == S_RUN) ? acc_d : acc_q;

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.neg_i(neg_lo_q), .a_i(fin_src), .y_o(prod_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i(neg_lo_q), .a_i(fin_src[WIDTH-1:0]), .y_o(quo_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i(neg_hi_q), .a_i(fin_src[2*WIDTH-1:WIDTH]), .y_o(rem_fix)
  );

  // Issue from IDLE (and any divide-by-zero) spends one armed cycle before RUN/FIN;
  // back-to-back issue from FIN goes straight to RUN.
  always_comb begin
    state_d = state_q;
    arm_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_q) begin
          state_d = zdiv_q ? S_FIN : S_RUN;
        end else if (Start) begin
          arm_d = 1'b1;
        end
      end
      S_RUN: begin
        if (last) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (Start) begin
          if (b_zero) arm_d = 1'b1;
          else        state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      is_div_q   <= 1'b0;
      zdiv_q     <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      result1_q  <= '0;
      result2_q  <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      if (accept) begin
        is_div_q   <= is_div;
        zdiv_q     <= b_zero;
        neg_lo_q   <= ~b_zero & (a_neg ^ b_neg);
        neg_hi_q   <= is_div ? (~b_zero & a_neg) : (a_neg ^ b_neg);
        div_zero_q <= 1'b0;
        acc_q      <= load_acc;
        mcand_q    <= {{WIDTH{1'b0}}, (is_div ? b_abs : a_abs)};
        mplier_q   <= b_abs;
        cnt_q      <= CNT_W'(WIDTH - 1);
      end else if (state_q == S_RUN) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
      if (state_d == S_FIN) begin
        result1_q  <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        result2_q  <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        div_zero_q <= zdiv_q;
      end
    end
  end

  assign Busy    = (state_q == S_RUN) | arm_q;
  assign Done    = (state_q == S_FIN);
  assign DivZero = div_zero_q;
  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule
